audio_sample_pacer: RTL and testbench

- Source end of the filter-chain sample interface.
- Accepts the streamed music byte stream (valid/ready, little-endian 16-bit samples) and buffers assembled samples in a small FIFO.
- Emits one 16-bit sample per audio period as `sample_out` plus a one-cycle `sample_en` strobe. This is exactly the enable/data pair the echo filter and circular buffer consume.
- Handles FIFO underrun deterministically so downstream filters always see a strobe at the fixed rate.

---
 rtl/audio_stream_pkg.sv | 15 +
 rtl/sample_fifo.sv | 62 ++++++
 rtl/audio_sample_pacer.sv | 122 ++++++++++++
 tb/tb_audio_sample_pacer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_stream_pkg.sv
// Shared definitions for the audio byte-stream blocks: widths, idle sample
// value and the byte-pair assembler state type.
package audio_stream_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned BYTE_W   = 8;

    localparam logic [SAMPLE_W-1:0] AUDIO_IDLE_SAMPLE = 16'h8000;

    typedef enum logic {
        ASM_LOW  = 1'b0,
        ASM_HIGH = 1'b1
    } asm_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with an explicit occupancy count so full and empty are
// distinguishable at DEPTH. DEPTH must be a power of two >= 2; pointers wrap
// naturally. Read data is the head entry, valid whenever empty is low.
module sample_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed, contents are only read when occupied.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                level <= level + LVL_W'(1);
            end else if (pop_ok && !push_ok) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/audio_sample_pacer.sv
// Audio sample pacer: assembles little-endian byte pairs into 16-bit samples,
// buffers them, and releases one sample per CLK_DIV cycles with a one-cycle
// sample_en strobe. An empty FIFO at strobe time raises underrun.
// Build option: AUDIO_SAMPLE_PACER_HOLD_LAST_EN keeps the previous sample on
// underrun instead of loading IDLE_VALUE.
module audio_sample_pacer
    import audio_stream_pkg::*;
#(
    parameter int unsigned          CLK_DIV    = 2083,
    parameter int unsigned          FIFO_DEPTH = 16,
    parameter logic [SAMPLE_W-1:0]  IDLE_VALUE = AUDIO_IDLE_SAMPLE
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic [BYTE_W-1:0]             byte_in,
    input  logic                          byte_valid,
    output logic                          byte_ready,
    output logic [SAMPLE_W-1:0]           sample_out,
    output logic                          sample_en,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned    CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    asm_state_e          state_q;
    asm_state_e          state_d;
    logic [BYTE_W-1:0]   low_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                accept_c;
    logic                push_c;
    logic                tc_c;
    logic                pop_c;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_dout;

    assign byte_ready = !fifo_full;
    assign accept_c   = byte_valid && byte_ready;
    assign tc_c       = enable && (cnt_q == CNT_LAST);
    assign pop_c      = tc_c && !fifo_empty;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_c),
        .pop    (pop_c),
        .din    ({byte_in, low_q}),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // Assembler state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ASM_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Assembler next state: low byte first, push on the high byte.
    always_comb begin
        state_d = state_q;
        push_c  = 1'b0;
        if (accept_c) begin
            if (state_q == ASM_LOW) begin
                state_d = ASM_HIGH;
            end else begin
                state_d = ASM_LOW;
                push_c  = 1'b1;
            end
        end
    end

    // Low byte holding register; cleared by reset so a split pair is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            low_q <= '0;
        end else if (accept_c && (state_q == ASM_LOW)) begin
            low_q <= byte_in;
        end
    end

    // Period counter; frozen, not cleared, while disabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Output sample, strobe and underrun pulse issued at terminal count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample_out <= IDLE_VALUE;
            sample_en  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sample_en <= tc_c;
            underrun  <= tc_c && fifo_empty;
            if (pop_c) begin
                sample_out <= fifo_dout;
            end
`ifdef AUDIO_SAMPLE_PACER_HOLD_LAST_EN
`else
            else if (tc_c) begin
                sample_out <= IDLE_VALUE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Self-checking bench for audio_sample_pacer (CLK_DIV=4, FIFO_DEPTH=4):
// directed scenarios with literal expectations plus randomized traffic, all
// checked every cycle against a queue-based model of the pacer.
module tb_audio_sample_pacer;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] IDLE       = 16'h8000;

    logic             clk = 1'b0;
    logic             resetn;
    logic             enable;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic [15:0]      sample_out;
    logic             sample_en;
    logic             underrun;
    logic [LVL_W-1:0] fifo_level;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int accepted = 0;
    bit chk_on = 1'b0;

    audio_sample_pacer #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .IDLE_VALUE (IDLE)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .sample_out (sample_out),
        .sample_en  (sample_en),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: queue of samples, pending low byte, enabled-cycle phase.
    logic [15:0] m_q[$];
    bit          m_have_low = 1'b0;
    logic [7:0]  m_low = 8'h00;
    int          m_phase = 0;
    logic [15:0] m_out = IDLE;
    bit          m_en = 1'b0;
    bit          m_und = 1'b0;

    always @(posedge clk or negedge resetn) begin
        bit acc;
        bit tc;
        if (!resetn) begin
            m_q.delete();
            m_have_low = 1'b0;
            m_phase    = 0;
            m_out      = IDLE;
            m_en       = 1'b0;
            m_und      = 1'b0;
        end else begin
            acc   = byte_valid && (m_q.size() < FIFO_DEPTH);
            tc    = enable && (m_phase == CLK_DIV - 1);
            m_en  = tc;
            m_und = 1'b0;
            if (tc) begin
                if (m_q.size() > 0) begin
                    m_out = m_q.pop_front();
                end else begin
                    m_und = 1'b1;
`ifndef AUDIO_SAMPLE_PACER_HOLD_LAST_EN
                    m_out = IDLE;
`endif
                end
            end
            if (acc) begin
                if (m_have_low) begin
                    m_q.push_back({byte_in, m_low});
                    m_have_low = 1'b0;
                end else begin
                    m_low      = byte_in;
                    m_have_low = 1'b1;
                end
            end
            if (enable) m_phase = (m_phase + 1) % CLK_DIV;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("sample_out", 32'(sample_out), 32'(m_out));
            check("sample_en",  32'(sample_en),  32'(m_en));
            check("underrun",   32'(underrun),   32'(m_und));
            check("byte_ready", 32'(byte_ready), 32'(m_q.size() < FIFO_DEPTH));
            check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        end
    end

    // Offer one byte until accepted; entered and left at posedge+2.
    task automatic send_byte(input logic [7:0] b);
        bit r;
        bit done;
        done       = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            r = byte_ready;
            @(posedge clk);
            #2;
            if (r) begin
                accepted++;
                done = 1'b1;
            end
        end
        byte_valid = 1'b0;
        if (!done) check("send_byte_timeout", 32'(0), 32'(1));
    endtask

    // Wait for the next strobe; returns at the negedge where it is visible.
    task automatic wait_strobe(output logic [15:0] v, output logic u, output int at);
        bit got;
        got = 1'b0;
        v   = 16'hxxxx;
        u   = 1'bx;
        at  = -1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (sample_en) begin
                got = 1'b1;
                v   = sample_out;
                u   = underrun;
                at  = cyc;
            end
        end
        if (!got) check("strobe_timeout", 32'(0), 32'(1));
    endtask

    logic [15:0] v1, v2, v3, v4, v5;
    logic        u1, u2, u3, u4, u5;
    int          t1, t2, t3, t4, t5;

    initial begin
        resetn     = 1'b1;
        enable     = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        #1 resetn  = 1'b0;
        #1 chk_on  = 1'b1;
        repeat (3) @(posedge clk);
        #2 resetn  = 1'b1;

        // Idle after reset: silence, no strobes, ready, empty.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_sample", 32'(sample_out), 32'(16'h8000));
            check("idle_en",     32'(sample_en),  32'(0));
            check("idle_ready",  32'(byte_ready), 32'(1));
            check("idle_level",  32'(fifo_level), 32'(0));
        end
        @(posedge clk); #2;

        // Ordering, spacing and first underrun.
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
        enable = 1'b1;
        wait_strobe(v1, u1, t1);
        wait_strobe(v2, u2, t2);
        wait_strobe(v3, u3, t3);
        check("order_s1", 32'(v1), 32'(16'h1234));
        check("order_u1", 32'(u1), 32'(0));
        check("order_s2", 32'(v2), 32'(16'h5678));
`ifdef AUDIO_SAMPLE_PACER_HOLD_LAST_EN
        check("order_s3", 32'(v3), 32'(16'h5678));
`else
        check("order_s3", 32'(v3), 32'(16'h8000));
`endif
        check("order_u3",   32'(u3),      32'(1));
        check("spacing_12", 32'(t2 - t1), 32'(4));
        check("spacing_23", 32'(t3 - t2), 32'(4));
        @(posedge clk); #2;
        enable = 1'b0;

        // Backpressure: ten bytes against a frozen pacer.
        accepted = 0;
        fork
            begin
                for (int i = 1; i <= 10; i++) send_byte(8'(i));
            end
            begin
                for (int i = 0; i < 100 && accepted < 8; i++) @(posedge clk);
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("bp_accepted", 32'(accepted),   32'(8));
                check("bp_ready",    32'(byte_ready), 32'(0));
                check("bp_level",    32'(fifo_level), 32'(4));
                @(posedge clk); #2;
                enable = 1'b1;
                wait_strobe(v1, u1, t1);
                wait_strobe(v2, u2, t2);
                wait_strobe(v3, u3, t3);
                wait_strobe(v4, u4, t4);
                wait_strobe(v5, u5, t5);
                check("bp_s1", 32'(v1), 32'(16'h0201));
                check("bp_s2", 32'(v2), 32'(16'h0403));
                check("bp_s3", 32'(v3), 32'(16'h0605));
                check("bp_s4", 32'(v4), 32'(16'h0807));
                check("bp_s5", 32'(v5), 32'(16'h0A09));
                check("bp_u5", 32'(u5), 32'(0));
            end
        join
        @(posedge clk); #2;
        enable = 1'b0;

        // Simultaneous push and pop on the terminal-count edge at level 2.
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hB0); send_byte(8'hB1);
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hD0);
        enable = 1'b1;
        wait_strobe(v1, u1, t1);
        check("pp_first",  32'(v1),         32'(16'hA1A0));
        check("pp_level0", 32'(fifo_level), 32'(2));
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        byte_in    = 8'hD1;
        byte_valid = 1'b1;
        @(posedge clk); #2;
        byte_valid = 1'b0;
        @(negedge clk);
        check("pp_strobe", 32'(sample_en),  32'(1));
        check("pp_value",  32'(sample_out), 32'(16'hB1B0));
        check("pp_level",  32'(fifo_level), 32'(2));
        wait_strobe(v2, u2, t2);
        wait_strobe(v3, u3, t3);
        check("pp_c", 32'(v2), 32'(16'hC1C0));
        check("pp_d", 32'(v3), 32'(16'hD1D0));
        @(posedge clk); #2;
        enable = 1'b0;

        // Async reset while a low byte is pending.
        send_byte(8'hAA);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_sample", 32'(sample_out), 32'(16'h8000));
        check("rst_level",  32'(fifo_level), 32'(0));
        @(posedge clk); #2;
        resetn = 1'b1;
        send_byte(8'h11); send_byte(8'h22);
        enable = 1'b1;
        wait_strobe(v1, u1, t1);
        check("rst_first", 32'(v1), 32'(16'h2211));
        check("rst_u",     32'(u1), 32'(0));
        @(posedge clk); #2;

        // Randomized traffic with varying byte density and enable duty.
        for (int seg = 0; seg < 4; seg++) begin
            int pv;
            pv = (seg == 0) ? 20 : (seg == 1) ? 60 : (seg == 2) ? 95 : 40;
            for (int i = 0; i < 250; i++) begin
                byte_valid = ($urandom_range(0, 99) < pv);
                byte_in    = 8'($urandom);
                enable     = ($urandom_range(0, 99) < 90);
                @(posedge clk); #2;
            end
        end
        byte_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
